// File: rtl/shift_reg_param.sv
// Parametrised multi-step shift register: clear/set/load in one cycle, shifts/rotates one bit per clock.
// Optional registered serial-out of the bit leaving the register: define SHREG_SEROUT_EN.
module shift_reg_param #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNTW-1:0]  cmd_amt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  input  logic             halt,
  output logic [WIDTH-1:0] reg_out,
  output logic             busy,
  output logic             done
`ifdef SHREG_SEROUT_EN
  ,
  output logic             ser_out
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]      state;
  logic [CNTW-1:0] cnt;
  logic [2:0]      op_q;
  logic            accept;
  logic            is_shift;

  function automatic logic [WIDTH-1:0] step(input logic [2:0] op,
                                            input logic [WIDTH-1:0] r,
                                            input logic si);
    logic [WIDTH-1:0] n;
    n = r;
    case (op)
      3'b011:  n = {1'b0, r[WIDTH-1:1]};
      3'b100:  n = {r[WIDTH-2:0], 1'b0};
      3'b101:  n = {r[WIDTH-1], r[WIDTH-1:1]};
      3'b110:  n = {si, r[WIDTH-1:1]};
      3'b111:  n = {r[0], r[WIDTH-1:1]};
      default: n = r;
    endcase
    return n;
  endfunction

  assign cmd_ready = (state == ST_IDLE) & ~halt;
  assign accept    = cmd_valid & cmd_ready;
  assign is_shift  = cmd_op[2] | (cmd_op[1] & cmd_op[0]);
  assign busy      = (state == ST_SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= 3'b000;
      reg_out <= '0;
      done    <= 1'b0;
`ifdef SHREG_SEROUT_EN
      ser_out <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!is_shift) begin
              case (cmd_op)
                3'b000:  reg_out <= '0;
                3'b001:  reg_out <= '1;
                default: reg_out <= load_data;
              endcase
              done <= 1'b1;
            end else if (cmd_amt == '0) begin
              done <= 1'b1;
            end else begin
              reg_out <= step(cmd_op, reg_out, ser_in);
`ifdef SHREG_SEROUT_EN
              ser_out <= (cmd_op == 3'b100) ? reg_out[WIDTH-1] : reg_out[0];
`endif
              if (cmd_amt == CNTW'(1)) begin
                done <= 1'b1;
              end else begin
                cnt   <= cmd_amt - 1'b1;
                op_q  <= cmd_op;
                state <= ST_SHIFT;
              end
            end
          end
        end
        default: begin
          // Abort keeps the partial value and suppresses completion.
          if (halt) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            reg_out <= step(op_q, reg_out, ser_in);
`ifdef SHREG_SEROUT_EN
            ser_out <= (op_q == 3'b100) ? reg_out[WIDTH-1] : reg_out[0];
`endif
            cnt <= cnt - 1'b1;
            if (cnt == CNTW'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_param.sv
// Randomized + directed bench for shift_reg_param against a closed-form step model.
`timescale 1ns/1ps
module tb_shift_reg_param;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          ser_in = 1'b0;
  logic          halt = 1'b0;
  logic [2:0]    cmd_op = 3'b000;
  logic [CW-1:0] cmd_amt = '0;
  logic [W-1:0]  load_data = '0;
  logic          cmd_ready, busy, done;
  logic [W-1:0]  reg_out;
`ifdef SHREG_SEROUT_EN
  logic          ser_out;
`endif

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic chk_en = 1'b0;
  logic [W-1:0] exp_reg = '0;
  logic exp_busy = 1'b0, exp_done = 1'b0, exp_rdy = 1'b1, exp_so = 1'b0;
  logic sb [0:15];

  always #5 clk = ~clk;

  shift_reg_param #(.WIDTH(W), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .load_data(load_data), .ser_in(ser_in),
    .halt(halt), .reg_out(reg_out), .busy(busy), .done(done)
`ifdef SHREG_SEROUT_EN
    , .ser_out(ser_out)
`endif
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Register value after k steps of op from v, in closed form.
  function automatic logic [W-1:0] after_steps(input logic [2:0] op, input logic [W-1:0] v, input int k);
    logic signed [W-1:0] s;
    logic [W-1:0] r;
    int rr;
    r = v;
    case (op)
      3'b011: r = (k >= W) ? '0 : v >> k;
      3'b100: r = (k >= W) ? '0 : v << k;
      3'b101: begin s = v; r = s >>> k; end
      3'b110: begin
        r = (k >= W) ? '0 : v >> k;
        for (int j = 0; j < k && j < W; j++) r[W-1-j] = sb[k-1-j];
      end
      3'b111: begin
        rr = k % W;
        r = (rr == 0) ? v : ((v >> rr) | (v << (W - rr)));
      end
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic bit_out(input logic [2:0] op, input logic [W-1:0] v);
    return (op == 3'b100) ? v[W-1] : v[0];
  endfunction

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      chk("reg_out", 32'(reg_out), 32'(exp_reg));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (rst) chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
`ifdef SHREG_SEROUT_EN
      chk("ser_out", 32'(ser_out), 32'(exp_so));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] op, input int amt, input logic [W-1:0] data,
                         input int halt_at, input int rst_at, input bit follow_clr);
    logic [W-1:0] orig;
    orig = exp_reg;
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = CW'(amt); load_data = data;
    ser_in = sb[0]; halt = 1'b0;
    tick();
    if (follow_clr) cmd_op = 3'b000;
    else cmd_valid = 1'b0;
    if (op < 3'b011) begin
      exp_reg  = (op == 3'b000) ? '0 : (op == 3'b001) ? '1 : data;
      exp_done = 1'b1;
    end else if (amt == 0) begin
      exp_done = 1'b1;
    end else begin
      exp_so  = bit_out(op, orig);
      exp_reg = after_steps(op, orig, 1);
      if (amt == 1) exp_done = 1'b1;
      else begin
        exp_busy = 1'b1; exp_rdy = 1'b0;
        for (int c = 1; c < amt; c++) begin
          if (c == rst_at) begin
            rst = 1'b0;
            #1;
            exp_reg = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_so = 1'b0;
            tick();
            rst = 1'b1; exp_rdy = 1'b1;
            return;
          end
          halt = (c == halt_at); ser_in = sb[c];
          tick();
          if (c == halt_at) begin
            halt = 1'b0; exp_busy = 1'b0; exp_rdy = 1'b1;
            break;
          end
          exp_so  = bit_out(op, after_steps(op, orig, c));
          exp_reg = after_steps(op, orig, c + 1);
          if (c + 1 == amt) begin
            exp_busy = 1'b0; exp_rdy = 1'b1; exp_done = 1'b1;
          end
        end
      end
    end
    tick();
    if (follow_clr) begin
      cmd_valid = 1'b0; exp_reg = '0; exp_done = 1'b1;
      tick();
    end
    exp_done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sb[i] = 1'b0;
    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg", 32'(reg_out), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b1;
    tick();

    run_cmd(3'b010, 0, 8'hB4, -1, -1, 0);
    busy_cnt = 0; done_cnt = 0;
    run_cmd(3'b011, 3, 8'h00, -1, -1, 0);
    chk("shr3_val", 32'(reg_out), 32'h16);
    chk("shr3_busy_cycles", 32'(busy_cnt), 32'd2);
    chk("shr3_done_pulses", 32'(done_cnt), 32'd1);

    run_cmd(3'b010, 0, 8'h81, -1, -1, 0);
    run_cmd(3'b111, 9, 8'h00, -1, -1, 0);
    chk("rot9_val", 32'(reg_out), 32'hC0);

    run_cmd(3'b010, 0, 8'h80, -1, -1, 0);
    run_cmd(3'b101, 15, 8'h00, -1, -1, 0);
    chk("asr15_val", 32'(reg_out), 32'hFF);

    run_cmd(3'b010, 0, 8'h00, -1, -1, 0);
    sb[0] = 1'b1; sb[1] = 1'b0; sb[2] = 1'b1; sb[3] = 1'b1;
    run_cmd(3'b110, 4, 8'h00, -1, -1, 0);
    chk("ser4_val", 32'(reg_out), 32'hD0);
`ifdef SHREG_SEROUT_EN
    chk("ser4_serout", 32'(ser_out), 32'h0);
`endif

    run_cmd(3'b010, 0, 8'hFF, -1, -1, 0);
    done_cnt = 0;
    run_cmd(3'b100, 8, 8'h00, 3, -1, 0);
    chk("halt_no_done", 32'(done_cnt), 32'd0);

    run_cmd(3'b010, 0, 8'h3C, -1, -1, 0);
    busy_cnt = 0; done_cnt = 0;
    run_cmd(3'b011, 0, 8'h00, -1, -1, 0);
    chk("amt0_val", 32'(reg_out), 32'h3C);
    chk("amt0_busy", 32'(busy_cnt), 32'd0);
    chk("amt0_done", 32'(done_cnt), 32'd1);

    run_cmd(3'b010, 0, 8'hA5, -1, -1, 0);
    run_cmd(3'b011, 5, 8'h00, -1, -1, 1);
    chk("held_clear", 32'(reg_out), 32'h0);

    cmd_valid = 1'b1; cmd_op = 3'b001; halt = 1'b1; exp_rdy = 1'b0;
    tick();
    cmd_valid = 1'b0; halt = 1'b0; exp_rdy = 1'b1;
    tick();
    chk("idle_halt_blocks", 32'(reg_out), 32'h0);

    run_cmd(3'b010, 0, 8'h77, -1, -1, 0);
    run_cmd(3'b101, 6, 8'h00, -1, 2, 0);
    chk("rst_mid_val", 32'(reg_out), 32'h0);
    run_cmd(3'b010, 0, 8'h5A, -1, -1, 0);
    chk("post_rst_load", 32'(reg_out), 32'h5A);

    for (int n = 0; n < 300; n++) begin
      logic [2:0] op;
      int amt, h, r;
      op  = 3'($urandom_range(0, 7));
      amt = $urandom_range(0, 15);
      h = -1; r = -1;
      if (amt >= 2 && $urandom_range(0, 3) == 0) h = $urandom_range(1, amt - 1);
      else if (amt >= 2 && $urandom_range(0, 19) == 0) r = $urandom_range(1, amt - 1);
      for (int i = 0; i < 16; i++) sb[i] = 1'($urandom_range(0, 1));
      run_cmd(op, amt, 8'($urandom), h, r, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
